// File: rtl/packet_meter.sv
// Serial packet meter: measures length and ones-count of packets framed by the
// upstream begP/endP detector, counts completed packets and flags framing errors.
module packet_meter #(
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_LEN = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dataIn,
  input  logic             begP,
  input  logic             endP,
  input  logic             errClr,
  output logic             pktValid,
  output logic [LEN_W-1:0] pktLen,
  output logic [LEN_W-1:0] pktOnes,
  output logic             pktLong,
  output logic [CNT_W-1:0] pktCount,
  output logic             protoErr
);

  // state | meaning
  // IDLE  | waiting for begP
  // RUN   | packet active, accumulating length and ones
  // DONE  | result registered, pktValid high this cycle
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] ones_q, ones_d;
  logic             emit;
  logic             err;

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] v,
                                               input logic inc);
    if (!inc || v == {LEN_W{1'b1}}) return v;
    return v + LEN_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ones_d  = ones_q;
    emit    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (begP && !endP) begin
          state_d = RUN;
          len_d   = LEN_W'(1);
          ones_d  = LEN_W'(dataIn);
        end else if (endP) begin
          err = 1'b1;
        end
      end
      RUN: begin
        if (begP && endP) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (begP) begin
          len_d  = sat_add(len_q, 1'b1);
          ones_d = sat_add(ones_q, dataIn);
        end else if (endP) begin
          emit    = 1'b1;
          state_d = DONE;
        end else begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (begP && endP) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (begP) begin
          state_d = RUN;
          len_d   = LEN_W'(1);
          ones_d  = LEN_W'(dataIn);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      ones_q   <= '0;
      pktLen   <= '0;
      pktOnes  <= '0;
      pktLong  <= 1'b0;
      pktCount <= '0;
      protoErr <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ones_q  <= ones_d;
      if (emit) begin
        pktLen   <= len_q;
        pktOnes  <= ones_q;
        pktLong  <= (len_q >= LEN_W'(MAX_LEN));
        pktCount <= pktCount + CNT_W'(1);
      end
      // a new error outranks a simultaneous clear
      if (err)         protoErr <= 1'b1;
      else if (errClr) protoErr <= 1'b0;
    end
  end

  assign pktValid = (state_q == DONE);

endmodule

// File: tb/tb_packet_meter.sv
// Directed bench for packet_meter: an integer-level packet model checked every
// cycle, plus literal expectations for the nominal, long, error and wrap cases.
module tb_packet_meter;

  logic       clk = 1'b0;
  logic       reset, dataIn, begP, endP, errClr;
  logic       v0, l0, v1, l1, e0, e1;
  logic [7:0] len0, ones0, len1, ones1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  packet_meter dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .begP(begP), .endP(endP),
    .errClr(errClr), .pktValid(v0), .pktLen(len0), .pktOnes(ones0),
    .pktLong(l0), .pktCount(cnt0), .protoErr(e0));

  packet_meter #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .dataIn(dataIn), .begP(begP), .endP(endP),
    .errClr(errClr), .pktValid(v1), .pktLen(len1), .pktOnes(ones1),
    .pktLong(l1), .pktCount(cnt1), .protoErr(e1));

  // model: unbounded integer tallies, saturation applied only when reported
  bit m_active, m_valid, m_long, m_err;
  int m_len, m_ones, m_olen, m_oones, m_cnt;

  always @(posedge clk) begin
    bit e;
    bit was_valid;
    if (reset) begin
      m_active = 0; m_valid = 0; m_long = 0; m_err = 0;
      m_len = 0; m_ones = 0; m_olen = 0; m_oones = 0; m_cnt = 0;
    end else begin
      e = 0;
      was_valid = m_valid;
      m_valid = 0;
      if (begP && endP) begin
        e = 1; m_active = 0;
      end else if (m_active && begP) begin
        m_len++; m_ones += dataIn;
      end else if (m_active && endP) begin
        m_olen  = (m_len  > 255) ? 255 : m_len;
        m_oones = (m_ones > 255) ? 255 : m_ones;
        m_long  = (m_olen >= 200);
        m_cnt++;
        m_valid = 1; m_active = 0;
      end else if (m_active) begin
        e = 1; m_active = 0;
      end else if (begP) begin
        m_active = 1; m_len = 1; m_ones = dataIn;
      end else if (endP && !was_valid) begin
        e = 1;
      end
      if (e) m_err = 1;
      else if (errClr) m_err = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("valid", v0, m_valid);
    chk("long",  l0, m_long);
    chk("err",   e0, m_err);
    chk("count", cnt0, m_cnt % 65536);
    chk("count4", cnt1, m_cnt % 16);
    chk("err4",  e1, m_err);
    chk("valid4", v1, m_valid);
    if (m_cnt > 0) begin
      chk("len",  len0, m_olen);
      chk("ones", ones0, m_oones);
    end else begin
      chk("len_rst",  len0, 0);
      chk("ones_rst", ones0, 0);
    end
  end

  task automatic cyc(input logic b, input logic e, input logic d = 1'b0,
                     input logic c = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    begP = b; endP = e; dataIn = d; errClr = c; reset = r;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic pkt(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'(i % 3 == 0));
    cyc(1'b0, 1'b1);
  endtask

  initial begin
    logic [5:0] pat;
    reset = 1'b1; begP = 0; endP = 0; dataIn = 0; errClr = 1'b1;
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 1, 1, 1);
    settle();
    chk("rst_cnt", cnt0, 0);
    chk("rst_err", e0, 0);
    chk("rst_valid", v0, 0);
    cyc(0, 0);

    // nominal 1,1,0,1,1,0
    pat = 6'b011011;
    for (int i = 0; i < 6; i++) cyc(1, 0, pat[i]);
    cyc(0, 1);
    settle();
    chk("nom_valid", v0, 1);
    chk("nom_len", len0, 6);
    chk("nom_ones", ones0, 4);
    chk("nom_long", l0, 0);
    chk("nom_cnt", cnt0, 1);
    cyc(0, 0);

    pkt(300);
    settle();
    chk("sat_len", len0, 255);
    chk("sat_long", l0, 1);
    cyc(0, 0);
    pkt(199);
    settle();
    chk("len199", len0, 199);
    chk("long199", l0, 0);
    cyc(0, 0);
    pkt(200);
    settle();
    chk("long200", l0, 1);
    cyc(0, 0);

    // protocol errors
    cyc(0, 1);
    settle();
    chk("idle_endp_err", e0, 1);
    chk("idle_endp_cnt", cnt0, 4);
    cyc(0, 0, 0, 1);
    settle();
    chk("clr", e0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1);
    cyc(0, 0);
    settle();
    chk("drop_err", e0, 1);
    chk("drop_valid", v0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0); cyc(1, 0);
    cyc(1, 1);
    settle();
    chk("both_err", e0, 1);
    cyc(0, 0, 0, 1);
    settle();
    chk("clr2", e0, 0);
    cyc(0, 1, 0, 1);
    settle();
    chk("err_beats_clr", e0, 1);
    cyc(0, 0, 0, 1);

    // back-to-back: second packet starts in the strobe cycle
    pkt(4);
    pkt(5);
    settle();
    chk("b2b_len", len0, 5);
    chk("b2b_cnt", cnt0, 6);
    cyc(0, 0);

    // reset mid-packet
    for (int i = 0; i < 3; i++) cyc(1, 0, 1);
    cyc(1, 0, 1, 0, 1);
    cyc(0, 1);
    settle();
    chk("rstmid_valid", v0, 0);
    chk("rstmid_cnt", cnt0, 0);
    chk("rstmid_err", e0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0);

    for (int k = 0; k < 17; k++) begin
      pkt(2);
      cyc(0, 0);
    end
    settle();
    chk("wrap4", cnt1, 1);
    chk("nowrap16", cnt0, 17);

    repeat (3) cyc(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_meter.md
PACKET_METER -- requirements
Module: packet_meter

Interface
REQ-001 Parameter LEN_W, default 8, width of the length and ones counters.
REQ-002 Parameter CNT_W, default 16, width of the packet counter.
REQ-003 Parameter MAX_LEN, default 200, length at or above which a packet is flagged long; legal range 1..2^LEN_W-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dataIn  input  1  serial data bit, same stream the upstream detector sees.
REQ-007 begP  input  1  packet-active level from the upstream detector.
REQ-008 endP  input  1  one-cycle end-of-packet pulse from the upstream detector.
REQ-009 errClr  input  1  clears the sticky protocol error flag.
REQ-010 pktValid  output  1  one-cycle strobe marking the result fields valid.
REQ-011 pktLen  output  LEN_W  packet length in cycles where begP was high, saturating.
REQ-012 pktOnes  output  LEN_W  count of dataIn=1 samples during begP-high cycles, saturating.
REQ-013 pktLong  output  1  set with pktValid when the final length is at least MAX_LEN.
REQ-014 pktCount  output  CNT_W  number of completed packets, wraps modulo 2^CNT_W.
REQ-015 protoErr  output  1  sticky flag for a begP/endP protocol violation.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE with begP=1 and endP=0: go to RUN; load length=1 and ones=dataIn.
REQ-018 In RUN with begP=1: stay in RUN; length+=1 and ones+=dataIn, each saturating at 2^LEN_W-1.
REQ-019 In RUN with begP=0 and endP=1: go to DONE; register pktLen, pktOnes and pktLong (pktLong = length>=MAX_LEN); increment pktCount.
REQ-020 In DONE: assert pktValid for exactly that cycle, then go to IDLE, or to RUN with length=1 if begP=1 (back-to-back packet).
REQ-021 Latency: pktValid SHALL be high in the cycle after the cycle in which endP is sampled high.
REQ-022 pktLen, pktOnes and pktLong SHALL hold their last values until the next packet completes.
REQ-023 Protocol errors set protoErr, produce no pktValid and leave pktCount unchanged. They are: begP=0 and endP=0 while in RUN (packet dropped, go to IDLE); endP=1 while in IDLE; begP=1 and endP=1 in the same cycle (go to IDLE).
REQ-024 errClr=1 clears protoErr next cycle; an error in the same cycle as errClr SHALL win, leaving protoErr set.
REQ-025 Saturation SHALL NOT wrap; a saturated pktLen SHALL still assert pktLong.
REQ-026 pktCount SHALL wrap from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, clear the internal counters, and clear pktValid, pktLen, pktOnes, pktLong, pktCount and protoErr, all to 0.
REQ-028 reset SHALL take priority over all other inputs, including errClr.
REQ-029 Reset mid-packet SHALL discard the packet, with no pktValid at any later cycle for it.

Verification
REQ-030 Nominal: begP high 6 cycles with dataIn 1,1,0,1,1,0, then endP pulse -> next cycle pktValid=1, pktLen=6, pktOnes=4, pktLong=0, pktCount=1.
REQ-031 Long/saturation, LEN_W=8, MAX_LEN=200: packet of 300 begP cycles -> pktLen=255, pktLong=1; then a packet of 199 cycles -> pktLen=199, pktLong=0.
REQ-032 Protocol errors: endP in IDLE -> protoErr=1, pktCount unchanged; begP falls without endP -> protoErr=1, no pktValid; begP and endP high together -> protoErr=1; errClr -> protoErr=0 next cycle.
REQ-033 Back-to-back: endP and begP of the next packet in the following cycle -> two pktValid strobes, pktCount increments by 2, second pktLen correct.
REQ-034 Reset mid-packet after 3 begP cycles, then endP -> no pktValid, pktCount=0, protoErr=1 (endP seen in IDLE).
REQ-035 Wrap, CNT_W=4: 17 complete packets -> pktCount=1.
